// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor: upstream operands plus a downstream result channel,
// each side using its own valid/ready pair.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] Data_A_In;
  logic [WIDTH-1:0] Data_B_In;
  logic             Borrow_In;
  logic             Valid_In;
  logic             Ready_Out;
  logic [WIDTH-1:0] Diff_Out;
  logic             Borrow_Out;
  logic             Zero_Out;
  logic             Valid_Out;
  logic             Ready_In;

  // slave: the subtractor itself; master: whoever supplies operands and consumes results
  modport slave (
    input  Data_A_In, Data_B_In, Borrow_In, Valid_In, Ready_In,
    output Ready_Out, Diff_Out, Borrow_Out, Zero_Out, Valid_Out
  );

  modport master (
    output Data_A_In, Data_B_In, Borrow_In, Valid_In, Ready_In,
    input  Ready_Out, Diff_Out, Borrow_Out, Zero_Out, Valid_Out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: Diff = A - B - Borrow_In, DIGIT bits per cycle, LS digit first,
// with the borrow carried between digits in a register.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                Clk,
  input  logic                Reset,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // Operands: Valid_In & Ready_Out (Ready_Out only in IDLE). Results: Valid_Out & Ready_In;
  // Valid_Out and the result stay stable until taken.

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_borrow;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_diff_out;
  logic             r_borrow_out;
  logic             r_zero;

  logic [DIGIT:0]   w_sub;
  logic [WIDTH-1:0] w_diff_next;

  // (DIGIT+1)-bit subtraction: the top bit is the borrow out of this digit.
  assign w_sub = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]} - {{DIGIT{1'b0}}, r_borrow};

  // Finished digits enter at the MS end so the result is aligned once the last digit lands.
  assign w_diff_next = (r_acc >> DIGIT) | (WIDTH'(w_sub[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_borrow     <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_valid      <= 1'b0;
      r_diff_out   <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Valid_In) begin
            r_a      <= bus.Data_A_In;
            r_b      <= bus.Data_B_In;
            r_borrow <= bus.Borrow_In;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_state  <= S_BUSY;
          end
        end

        S_BUSY: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_borrow <= w_sub[DIGIT];
          r_acc    <= w_diff_next;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_diff_out   <= w_diff_next;
            r_borrow_out <= w_sub[DIGIT];
            r_zero       <= (w_diff_next == '0);
            r_valid      <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          // Result fields keep their value after the take; only the handshake flags move.
          if (bus.Ready_In) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Ready_Out  = r_ready;
  assign bus.Valid_Out  = r_valid;
  assign bus.Diff_Out   = r_diff_out;
  assign bus.Borrow_Out = r_borrow_out;
  assign bus.Zero_Out   = r_zero;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: DIGIT=2 main instance plus DIGIT=1 and DIGIT=8 instances
// sharing clock and reset, scoreboarded against a full-width A-B-Bin model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int W     = WIDTH + 2;   // {borrow, zero, diff}

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus2 ();
  serial_subtractor_if #(.WIDTH(WIDTH)) bus1 ();
  serial_subtractor_if #(.WIDTH(WIDTH)) bus8 ();

  logic [1:0] st2, st1, st8;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(2)) dut2 (.Clk(clk), .Reset(rst), .bus(bus2), .o_dbg_state(st2));
  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(1)) dut1 (.Clk(clk), .Reset(rst), .bus(bus1), .o_dbg_state(st1));
  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(8)) dut8 (.Clk(clk), .Reset(rst), .bus(bus8), .o_dbg_state(st8));

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q8[$];

  function automatic logic [W-1:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] t;
    t = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    return {t[8], (t[7:0] == 8'h00), t[7:0]};
  endfunction

  task automatic idle_inputs();
    bus2.Data_A_In = '0; bus2.Data_B_In = '0; bus2.Borrow_In = 1'b0; bus2.Valid_In = 1'b0; bus2.Ready_In = 1'b0;
    bus1.Data_A_In = '0; bus1.Data_B_In = '0; bus1.Borrow_In = 1'b0; bus1.Valid_In = 1'b0; bus1.Ready_In = 1'b0;
    bus8.Data_A_In = '0; bus8.Data_B_In = '0; bus8.Borrow_In = 1'b0; bus8.Valid_In = 1'b0; bus8.Ready_In = 1'b0;
  endtask

  // One full transaction on the DIGIT=2 instance: accept, latency, result, take.
  task automatic run_op2(input logic [7:0] a, input logic [7:0] b, input logic bin, input string name);
    int lat;
    logic [W-1:0] exp;
    logic [W-1:0] act;
    lat = 0;
    while (bus2.Ready_Out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (bus2.Ready_Out !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, bus2.Ready_Out);
    end
    bus2.Data_A_In = a; bus2.Data_B_In = b; bus2.Borrow_In = bin; bus2.Valid_In = 1'b1;
    exp_q.push_back(model(a, b, bin));
    @(posedge clk); #1;
    bus2.Valid_In = 1'b0;
    bus2.Data_A_In = 8'($urandom); bus2.Data_B_In = 8'($urandom); bus2.Borrow_In = 1'($urandom);
    lat = 0;
    while (bus2.Valid_Out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL %s latency: got %0d expected 4", name, lat);
    end
    n_checks++;
    if (bus2.Ready_Out !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_in_done: got %b expected 0", name, bus2.Ready_Out);
    end
    exp = exp_q.pop_front();
    act = {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out};
    n_checks++;
    if (act !== exp) begin
      n_fail++; $display("FAIL %s result: got %h expected %h", name, act, exp);
    end
    bus2.Ready_In = 1'b1;
    @(posedge clk); #1;
    bus2.Ready_In = 1'b0;
    n_checks++;
    if ({bus2.Valid_Out, bus2.Ready_Out} !== 2'b01) begin
      n_fail++; $display("FAIL %s after_take valid/ready: got %b expected 01", name, {bus2.Valid_Out, bus2.Ready_Out});
    end
    act = {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out};
    n_checks++;
    if (act !== exp) begin
      n_fail++; $display("FAIL %s result_kept: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus2.Ready_Out, bus2.Valid_Out} !== 2'b10) begin
      n_fail++; $display("FAIL reset ready/valid: got %b expected 10", {bus2.Ready_Out, bus2.Valid_Out});
    end
    n_checks++;
    if ({bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out} !== '0) begin
      n_fail++; $display("FAIL reset outputs: got %h expected 0", {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out});
    end
    n_checks++;
    if ({st2, st1, st8} !== 6'b0) begin
      n_fail++; $display("FAIL reset state: got %b expected 000000", {st2, st1, st8});
    end
    n_checks++;
    if ({bus1.Ready_Out, bus8.Ready_Out, bus1.Valid_Out, bus8.Valid_Out} !== 4'b1100) begin
      n_fail++; $display("FAIL reset variants ready/valid: got %b expected 1100",
                         {bus1.Ready_Out, bus8.Ready_Out, bus1.Valid_Out, bus8.Valid_Out});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    run_op2(8'h5A, 8'h3C, 1'b0, "vec_5a_3c");
    run_op2(8'h3C, 8'h5A, 1'b0, "vec_3c_5a");
    run_op2(8'h00, 8'h00, 1'b1, "vec_00_00_b1");
    run_op2(8'h80, 8'h7F, 1'b1, "vec_80_7f_b1");
    run_op2(8'hFF, 8'hFF, 1'b1, "vec_ff_ff_b1");
    run_op2(8'hFF, 8'h00, 1'b0, "vec_ff_00");
    run_op2(8'h00, 8'hFF, 1'b1, "vec_00_ff_b1");
    for (int i = 0; i < 16; i++)
      run_op2(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "vec_rand");
  endtask

  task automatic test_hold();
    int lat;
    logic [W-1:0] exp;
    logic [W-1:0] act;
    logic [7:0] a2, b2;
    logic bin2;
    bus2.Data_A_In = 8'hC3; bus2.Data_B_In = 8'h21; bus2.Borrow_In = 1'b1; bus2.Valid_In = 1'b1;
    exp_q.push_back(model(8'hC3, 8'h21, 1'b1));
    @(posedge clk); #1;
    bus2.Valid_In = 1'b0;
    lat = 0;
    while (bus2.Valid_Out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL hold latency: got %0d expected 4", lat);
    end
    exp = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      bus2.Valid_In = ~bus2.Valid_In;
      bus2.Data_A_In = 8'($urandom); bus2.Data_B_In = 8'($urandom); bus2.Borrow_In = 1'($urandom);
      @(posedge clk); #1;
      act = {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out};
      n_checks++;
      if (act !== exp) begin
        n_fail++; $display("FAIL hold result cycle %0d: got %h expected %h", i, act, exp);
      end
      n_checks++;
      if ({bus2.Valid_Out, bus2.Ready_Out, st2} !== 4'b1010) begin
        n_fail++; $display("FAIL hold flags cycle %0d: got %b expected 1010", i, {bus2.Valid_Out, bus2.Ready_Out, st2});
      end
    end
    a2 = 8'h47; b2 = 8'h9B; bin2 = 1'b0;
    bus2.Data_A_In = a2; bus2.Data_B_In = b2; bus2.Borrow_In = bin2;
    bus2.Valid_In = 1'b1; bus2.Ready_In = 1'b1;
    exp_q.push_back(model(a2, b2, bin2));
    @(posedge clk); #1;
    bus2.Ready_In = 1'b0;
    n_checks++;
    if ({bus2.Valid_Out, bus2.Ready_Out, st2} !== 4'b0100) begin
      n_fail++; $display("FAIL hold take flags: got %b expected 0100", {bus2.Valid_Out, bus2.Ready_Out, st2});
    end
    @(posedge clk); #1;
    bus2.Valid_In = 1'b0;
    n_checks++;
    if ({bus2.Ready_Out, st2} !== 3'b001) begin
      n_fail++; $display("FAIL hold second accept: got %b expected 001", {bus2.Ready_Out, st2});
    end
    lat = 0;
    while (bus2.Valid_Out !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== 4) begin
      n_fail++; $display("FAIL hold second latency: got %0d expected 4", lat);
    end
    exp = exp_q.pop_front();
    act = {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out};
    n_checks++;
    if (act !== exp) begin
      n_fail++; $display("FAIL hold second result: got %h expected %h", act, exp);
    end
    bus2.Ready_In = 1'b1;
    @(posedge clk); #1;
    bus2.Ready_In = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus2.Data_A_In = 8'hE7; bus2.Data_B_In = 8'h18; bus2.Borrow_In = 1'b0; bus2.Valid_In = 1'b1;
    @(posedge clk); #1;
    bus2.Valid_In = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (st2 !== 2'd1) begin
      n_fail++; $display("FAIL reset_mid busy: got %0d expected 1", st2);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus2.Ready_Out, bus2.Valid_Out, st2} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_mid flags: got %b expected 1000", {bus2.Ready_Out, bus2.Valid_Out, st2});
    end
    n_checks++;
    if ({bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out} !== '0) begin
      n_fail++; $display("FAIL reset_mid outputs: got %h expected 0", {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus2.Valid_Out !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid spurious valid cycle %0d: got %b expected 0", i, bus2.Valid_Out);
      end
    end
    run_op2(8'h5A, 8'h3C, 1'b0, "reset_mid_next");
  endtask

  task automatic test_back_to_back();
    int n_sent, n_done, cyc, last_acc;
    logic accepted;
    logic [W-1:0] exp;
    logic [W-1:0] act;
    n_sent = 0; n_done = 0; cyc = 0; last_acc = 0;
    bus2.Data_A_In = 8'($urandom); bus2.Data_B_In = 8'($urandom); bus2.Borrow_In = 1'($urandom);
    bus2.Valid_In = 1'b1; bus2.Ready_In = 1'b1;
    while (n_done < 6 && cyc < 200) begin
      accepted = 1'b0;
      if (bus2.Valid_Out === 1'b1) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        act = {bus2.Borrow_Out, bus2.Zero_Out, bus2.Diff_Out};
        n_checks++;
        if (act !== exp) begin
          n_fail++; $display("FAIL b2b result %0d: got %h expected %h", n_done, act, exp);
        end
        n_done++;
      end
      if (bus2.Ready_Out === 1'b1 && bus2.Valid_In === 1'b1) begin
        exp_q.push_back(model(bus2.Data_A_In, bus2.Data_B_In, bus2.Borrow_In));
        if (n_sent > 0) begin
          n_checks++;
          if (cyc - last_acc !== 6) begin
            n_fail++; $display("FAIL b2b spacing: got %0d expected 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        n_sent++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        bus2.Data_A_In = 8'($urandom); bus2.Data_B_In = 8'($urandom); bus2.Borrow_In = 1'($urandom);
        if (n_sent >= 6) bus2.Valid_In = 1'b0;
      end
    end
    bus2.Valid_In = 1'b0; bus2.Ready_In = 1'b0;
    n_checks++;
    if (n_done !== 6 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b completion: got %0d done, %0d pending, expected 6 done, 0 pending", n_done, exp_q.size());
    end
  endtask

  task automatic test_digit_variants();
    logic [7:0] ca[8];
    logic [7:0] cb[8];
    logic [7:0] a, b;
    logic bin;
    int lat, lat1, lat8;
    logic [W-1:0] exp;
    logic [W-1:0] act;
    ca = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h5A, 8'h3C, 8'h01};
    cb = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h3C, 8'h5A, 8'h01};
    for (int i = 0; i < 136; i++) begin
      if (i < 16) begin
        a = ca[i % 8]; b = cb[i % 8]; bin = 1'(i / 8);
      end else begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255)); bin = 1'($urandom_range(0, 1));
      end
      n_checks++;
      if ({bus1.Ready_Out, bus8.Ready_Out} !== 2'b11) begin
        n_fail++; $display("FAIL variants ready op %0d: got %b expected 11", i, {bus1.Ready_Out, bus8.Ready_Out});
      end
      bus1.Data_A_In = a; bus1.Data_B_In = b; bus1.Borrow_In = bin; bus1.Valid_In = 1'b1;
      bus8.Data_A_In = a; bus8.Data_B_In = b; bus8.Borrow_In = bin; bus8.Valid_In = 1'b1;
      exp_q1.push_back(model(a, b, bin));
      exp_q8.push_back(model(a, b, bin));
      @(posedge clk); #1;
      bus1.Valid_In = 1'b0; bus8.Valid_In = 1'b0;
      lat = 0; lat1 = -1; lat8 = -1;
      while ((lat1 < 0 || lat8 < 0) && lat < 30) begin
        @(posedge clk); #1; lat++;
        if (lat1 < 0 && bus1.Valid_Out === 1'b1) lat1 = lat;
        if (lat8 < 0 && bus8.Valid_Out === 1'b1) lat8 = lat;
      end
      n_checks++;
      if (lat1 !== 8 || lat8 !== 1) begin
        n_fail++; $display("FAIL variants latency op %0d: got d1=%0d d8=%0d expected d1=8 d8=1", i, lat1, lat8);
      end
      exp = exp_q1.pop_front();
      act = {bus1.Borrow_Out, bus1.Zero_Out, bus1.Diff_Out};
      n_checks++;
      if (act !== exp) begin
        n_fail++; $display("FAIL d1 result a=%h b=%h bin=%b: got %h expected %h", a, b, bin, act, exp);
      end
      exp = exp_q8.pop_front();
      act = {bus8.Borrow_Out, bus8.Zero_Out, bus8.Diff_Out};
      n_checks++;
      if (act !== exp) begin
        n_fail++; $display("FAIL d8 result a=%h b=%h bin=%b: got %h expected %h", a, b, bin, act, exp);
      end
      bus1.Ready_In = 1'b1; bus8.Ready_In = 1'b1;
      @(posedge clk); #1;
      bus1.Ready_In = 1'b0; bus8.Ready_In = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_digit_variants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
